output_buffer_ctrl: RTL and testbench

- Sequencer for the partial-output buffer: accepts a stream of MAC partial sums, runs single-cycle read-modify-write accumulation into the addressed entry, then drains the entries in order over a valid/ready output stream.
- Each entry is cleared as it is drained, so the next pass starts from zero.
- Sits between the PE array (psum producer) and the buffer storage; it owns both buffer ports.

---
 rtl/output_buffer_ctrl.sv | 157 +++++++++++++++
 tb/tb_output_buffer_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_buffer_ctrl.sv
// Partial-output buffer sequencer: read-modify-write accumulation of psums, then an ordered
// clear-on-drain output stream. Define OUTPUT_BUF_CTRL_SAT_EN for a saturating accumulate add.
`ifndef OUTPUT_BUF_NUM
`define OUTPUT_BUF_NUM 4
`endif
`ifndef PARTIAL_OUT_SIZE
`define PARTIAL_OUT_SIZE 16
`endif

module output_buffer_ctrl #(
  parameter int BUF_NUM = `OUTPUT_BUF_NUM,
  parameter int DAT_W   = `PARTIAL_OUT_SIZE,
  parameter int SEL_W   = $clog2(BUF_NUM)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [SEL_W:0]   drain_num_i,
  input  logic             psum_val_i,
  output logic             psum_rdy_o,
  input  logic [SEL_W-1:0] psum_sel_i,
  input  logic [DAT_W-1:0] psum_dat_i,
  input  logic             psum_first_i,
  input  logic             psum_last_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [SEL_W-1:0] out_idx_o,
  output logic [DAT_W-1:0] out_dat_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [SEL_W-1:0] buf_acc_sel_o,
  output logic             buf_acc_val_o,
  output logic [DAT_W-1:0] buf_acc_dat_o,
  input  logic [DAT_W-1:0] buf_acc_dat_i,
  output logic [SEL_W-1:0] buf_out_sel_o,
  input  logic [DAT_W-1:0] buf_out_dat_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [SEL_W:0] NUM_MAX = (SEL_W+1)'(BUF_NUM);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W:0]   drain_num_q, drain_num_d;
  logic [SEL_W:0]   drain_clamped;
  logic [SEL_W:0]   drain_last;
  logic             cnt_at_last;
  logic             done_q, done_d;
  logic [DAT_W-1:0] acc_sum;

  assign drain_clamped = (drain_num_i > NUM_MAX) ? NUM_MAX : drain_num_i;
  assign drain_last    = drain_num_q - (SEL_W+1)'(1);
  assign cnt_at_last   = ({1'b0, cnt_q} == drain_last);

`ifdef OUTPUT_BUF_CTRL_SAT_EN
  localparam logic [DAT_W-1:0] SAT_MAX = {1'b0, {(DAT_W-1){1'b1}}};
  localparam logic [DAT_W-1:0] SAT_MIN = {1'b1, {(DAT_W-1){1'b0}}};
  logic [DAT_W:0] sum_ext;

  // One guard bit: overflow shows up as disagreement between the two top bits.
  assign sum_ext = {buf_acc_dat_i[DAT_W-1], buf_acc_dat_i} + {psum_dat_i[DAT_W-1], psum_dat_i};
  assign acc_sum = (sum_ext[DAT_W] != sum_ext[DAT_W-1]) ? (sum_ext[DAT_W] ? SAT_MIN : SAT_MAX)
                                                        : sum_ext[DAT_W-1:0];
`else
  assign acc_sum = buf_acc_dat_i + psum_dat_i;
`endif

  // Combinational outputs are forced to zero while rst_i is high so no handshake completes then.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain_num_d   = drain_num_q;
    done_d        = 1'b0;
    psum_rdy_o    = 1'b0;
    out_vld_o     = 1'b0;
    out_idx_o     = '0;
    out_dat_o     = '0;
    out_last_o    = 1'b0;
    buf_acc_sel_o = '0;
    buf_acc_val_o = 1'b0;
    buf_acc_dat_o = '0;
    buf_out_sel_o = '0;

    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d     = ACCUM;
            drain_num_d = drain_clamped;
            cnt_d       = '0;
          end
        end

        ACCUM: begin
          psum_rdy_o    = 1'b1;
          buf_acc_sel_o = psum_sel_i;
          buf_acc_val_o = psum_val_i;
          buf_acc_dat_o = psum_first_i ? psum_dat_i : acc_sum;
          if (psum_val_i && psum_last_i) begin
            if (drain_num_q == '0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end
        end

        DRAIN: begin
          out_vld_o     = 1'b1;
          out_idx_o     = cnt_q;
          buf_out_sel_o = cnt_q;
          out_dat_o     = buf_out_dat_i;
          out_last_o    = cnt_at_last;
          if (out_rdy_i) begin
            // Clear the entry as it leaves so the next pass starts from zero.
            buf_acc_sel_o = cnt_q;
            buf_acc_val_o = 1'b1;
            cnt_d         = cnt_q + SEL_W'(1);
            if (cnt_at_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE) && !rst_i;
  assign done_o = done_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drain_num_q <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_num_q <= drain_num_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Bench for output_buffer_ctrl: directed scenarios plus random passes against an entry-level
// reference model; the buffer storage itself is modelled here as the DUT's external memory.
module tb_output_buffer_ctrl;

  localparam int BUF_NUM = 4;
  localparam int DAT_W   = 16;
  localparam int SEL_W   = 2;
  localparam int SMAX    = (1 << (DAT_W-1)) - 1;
  localparam int SMIN    = -(1 << (DAT_W-1));
`ifdef OUTPUT_BUF_CTRL_SAT_EN
  localparam logic [DAT_W-1:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [DAT_W-1:0] SAT_EXP = 16'h8010;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [SEL_W:0]   drain_num_i;
  logic             psum_val_i;
  logic             psum_rdy_o;
  logic [SEL_W-1:0] psum_sel_i;
  logic [DAT_W-1:0] psum_dat_i;
  logic             psum_first_i;
  logic             psum_last_i;
  logic             out_vld_o;
  logic             out_rdy_i;
  logic [SEL_W-1:0] out_idx_o;
  logic [DAT_W-1:0] out_dat_o;
  logic             out_last_o;
  logic             busy_o;
  logic             done_o;
  logic [SEL_W-1:0] buf_acc_sel_o;
  logic             buf_acc_val_o;
  logic [DAT_W-1:0] buf_acc_dat_o;
  logic [DAT_W-1:0] buf_acc_dat_i;
  logic [SEL_W-1:0] buf_out_sel_o;
  logic [DAT_W-1:0] buf_out_dat_i;

  logic [DAT_W-1:0] buf_mem [BUF_NUM];
  logic [DAT_W-1:0] ref_mem [BUF_NUM];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  output_buffer_ctrl #(.BUF_NUM(BUF_NUM), .DAT_W(DAT_W), .SEL_W(SEL_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .drain_num_i(drain_num_i),
    .psum_val_i(psum_val_i), .psum_rdy_o(psum_rdy_o), .psum_sel_i(psum_sel_i),
    .psum_dat_i(psum_dat_i), .psum_first_i(psum_first_i), .psum_last_i(psum_last_i),
    .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .out_idx_o(out_idx_o),
    .out_dat_o(out_dat_o), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o),
    .buf_acc_sel_o(buf_acc_sel_o), .buf_acc_val_o(buf_acc_val_o),
    .buf_acc_dat_o(buf_acc_dat_o), .buf_acc_dat_i(buf_acc_dat_i),
    .buf_out_sel_o(buf_out_sel_o), .buf_out_dat_i(buf_out_dat_i)
  );

  // External buffer storage: synchronous write, combinational reads, cleared by rst_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_NUM; i++) buf_mem[i] <= '0;
    end else if (buf_acc_val_o) begin
      buf_mem[buf_acc_sel_o] <= buf_acc_dat_o;
    end
  end
  assign buf_acc_dat_i = buf_mem[buf_acc_sel_o];
  assign buf_out_dat_i = buf_mem[buf_out_sel_o];

  function automatic logic [DAT_W-1:0] ref_add(input logic [DAT_W-1:0] a, input logic [DAT_W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef OUTPUT_BUF_CTRL_SAT_EN
    if (s > SMAX) s = SMAX;
    if (s < SMIN) s = SMIN;
`endif
    return DAT_W'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    start_i      = 1'b0;
    drain_num_i  = '0;
    psum_val_i   = 1'b0;
    psum_sel_i   = '0;
    psum_dat_i   = '0;
    psum_first_i = 1'b0;
    psum_last_i  = 1'b0;
    out_rdy_i    = 1'b0;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < BUF_NUM; i++) ref_mem[i] = '0;
  endtask

  task automatic start_pass(input int n, output int eff);
    @(negedge clk_i);
    idle_inputs();
    start_i     = 1'b1;
    drain_num_i = (SEL_W+1)'(n);
    #1;
    check("idle_busy", busy_o, 0);
    check("idle_psum_rdy", psum_rdy_o, 0);
    eff = (n > BUF_NUM) ? BUF_NUM : n;
    @(negedge clk_i);
    idle_inputs();
    #1;
    check("accum_busy", busy_o, 1);
    check("accum_psum_rdy", psum_rdy_o, 1);
  endtask

  task automatic send_psum(input int sel, input logic [DAT_W-1:0] dat, input bit first,
                           input bit last, input bit poke_start);
    logic [DAT_W-1:0] exp;
    @(negedge clk_i);
    idle_inputs();
    psum_val_i   = 1'b1;
    psum_sel_i   = SEL_W'(sel);
    psum_dat_i   = dat;
    psum_first_i = first;
    psum_last_i  = last;
    start_i      = poke_start;
    drain_num_i  = 3'd1;
    exp = first ? dat : ref_add(ref_mem[sel], dat);
    #1;
    check("psum_rdy", psum_rdy_o, 1);
    check("acc_val", buf_acc_val_o, 1);
    check("acc_sel", buf_acc_sel_o, sel);
    check("acc_dat", buf_acc_dat_o, exp);
    ref_mem[sel] = exp;
  endtask

  task automatic finish_pass();
    @(negedge clk_i);
    idle_inputs();
    #1;
    check("done_pulse", done_o, 1);
    check("done_busy", busy_o, 0);
    check("done_vld", out_vld_o, 0);
    @(negedge clk_i);
    #1;
    check("done_clear", done_o, 0);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1 then ready, 2: random ready
  task automatic drain(input int n, input int mode);
    int   idx;
    int   cyc;
    logic rdy;
    logic [3:0] pat;
    idx = 0;
    cyc = 0;
    pat = 4'b1001;
    while (idx < n && cyc < 64) begin
      @(negedge clk_i);
      idle_inputs();
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc < 4) ? pat[cyc] : 1'b1;
      else                rdy = 1'($urandom_range(0, 1));
      out_rdy_i = rdy;
      #1;
      check("out_vld", out_vld_o, 1);
      check("out_idx", out_idx_o, idx);
      check("out_dat", out_dat_o, ref_mem[idx]);
      check("out_last", out_last_o, (idx == n-1));
      check("drain_psum_rdy", psum_rdy_o, 0);
      check("drain_acc_val", buf_acc_val_o, rdy);
      if (rdy) begin
        check("clear_sel", buf_acc_sel_o, idx);
        check("clear_dat", buf_acc_dat_o, 0);
        ref_mem[idx] = '0;
        idx++;
      end
      cyc++;
    end
    if (idx < n) check("drain_timeout", idx, n);
    finish_pass();
  endtask

  initial begin
    int eff;
    int k;
    idle_inputs();
    clear_ref();
    rst_i = 1'b1;

    // Reset state
    @(negedge clk_i);
    #1;
    check("rst_psum_rdy", psum_rdy_o, 0);
    check("rst_vld", out_vld_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_acc_val", buf_acc_val_o, 0);
    check("rst_acc_sel", buf_acc_sel_o, 0);
    check("rst_out_sel", buf_out_sel_o, 0);
    check("rst_idx", out_idx_o, 0);
    check("rst_last", out_last_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("post_rst_busy", busy_o, 0);

    // Basic accumulate and drain: expected 12,0,7,0, then an all-zero pass
    start_pass(4, eff);
    send_psum(0, 16'd5, 1, 0, 0);
    send_psum(0, 16'd7, 0, 0, 0);
    send_psum(2, -16'sd3, 1, 0, 0);
    send_psum(2, 16'd10, 0, 1, 0);
    drain(eff, 0);
    start_pass(4, eff);
    send_psum(3, 16'd0, 0, 1, 0);
    drain(eff, 0);

    // Back-to-back psums to one entry, start_i ignored in ACCUM, stalled drain
    start_pass(2, eff);
    send_psum(1, 16'd1, 1, 0, 0);
    send_psum(1, 16'd2, 0, 0, 1);
    send_psum(1, 16'd3, 0, 1, 0);
    drain(eff, 1);

    // Partial drain leaves entry 2 intact for the following pass
    start_pass(2, eff);
    send_psum(0, 16'd4, 1, 0, 0);
    send_psum(2, 16'd11, 1, 0, 0);
    send_psum(1, 16'd5, 1, 1, 0);
    drain(eff, 0);
    start_pass(4, eff);
    send_psum(3, 16'd1, 1, 1, 0);
    drain(eff, 0);

    // Zero-length drain
    start_pass(0, eff);
    send_psum(0, 16'd8, 1, 1, 0);
    finish_pass();

    // Signed overflow on accumulate; drain_num above BUF_NUM clamps
    start_pass(5, eff);
    send_psum(0, 16'h7FF0, 1, 0, 0);
    send_psum(0, 16'h0020, 0, 1, 0);
    @(negedge clk_i);
    idle_inputs();
    #1;
    check("overflow_dat", out_dat_o, SAT_EXP);
    drain(eff, 0);

    // Reset in the middle of a drain
    start_pass(4, eff);
    send_psum(1, 16'd9, 1, 0, 0);
    send_psum(3, 16'd4, 1, 1, 0);
    @(negedge clk_i);
    idle_inputs();
    out_rdy_i = 1'b1;
    rst_i     = 1'b1;
    #1;
    check("rst_mid_vld", out_vld_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_vld2", out_vld_o, 0);
    clear_ref();
    start_pass(4, eff);
    send_psum(0, 16'd0, 0, 1, 0);
    drain(eff, 0);

    // Random passes
    for (int p = 0; p < 8; p++) begin
      start_pass($urandom_range(0, 7), eff);
      k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) begin
        send_psum($urandom_range(0, BUF_NUM-1), DAT_W'($urandom), ($urandom_range(0, 3) == 0),
                  (j == k-1), 1'($urandom_range(0, 1)));
      end
      if (eff == 0) finish_pass();
      else          drain(eff, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
